phys_reg_free_list: RTL and testbench
=====================================

// Module: phys_reg_free_list
// PURPOSE
//  Circular FIFO of unallocated physical register tags. Sits upstream of the active list in rename.
//  Rename pops a tag for each destination; the active list pushes back each committed entry's old tag.
//  Supports one branch checkpoint of the read pointer, restored on flush (mispredict recovery).
// PARAMETERS
//  PHYS_REGS   64  number of physical registers
//  ARCH_REGS   32  number of architectural registers (identity-mapped at reset)
//  TAG_W       6   physical tag width, = $clog2(PHYS_REGS)
//  DEPTH       32  FIFO entries, = PHYS_REGS - ARCH_REGS
// PORTS
//  clk            in   1      core clock
//  rst_n          in   1      asynchronous, active-low reset
//  alloc_req      in   1      rename wants one tag this cycle
//  alloc_ready    out  1      free list non-empty; alloc fires when alloc_req && alloc_ready && !flush
//  alloc_tag      out  TAG_W  tag at head; valid whenever alloc_ready
//  free_valid     in   1      commit returns a tag this cycle
//  free_tag       in   TAG_W  tag being returned (old mapping of committed dest)
//  ckpt_save      in   1      snapshot read pointer (branch renamed this cycle)
//  flush          in   1      restore read pointer from snapshot
//  free_count     out  TAG_W  number of free tags (0..DEPTH)
//  overflow_err   out  1      sticky: push attempted while full
// BEHAVIOUR
//  - Storage: DEPTH x TAG_W array; head/tail pointers $clog2(DEPTH)+1 bits (MSB = wrap bit).
//  - Reset (async, rst_n=0): entry[i]=ARCH_REGS+i, head=0, tail={1'b1,0} (full).
//    Outputs: alloc_ready=1, alloc_tag=32, free_count=32, overflow_err=0.
//  - empty = (head==tail); full = (head[MSB]!=tail[MSB]) && (low bits equal).
//  - alloc_tag = entry[head low bits], combinational from registered state.
//  - Alloc: head+1 at clk edge, zero latency to rename. No alloc when empty.
//  - Free: entry[tail]=free_tag, tail+1 at clk edge.
//  - free_tag==0 is ignored, no push. Phys reg 0 is permanently $zero.
//  - Free while full: dropped, overflow_err set until reset.
//  - No bypass: alloc+free in same cycle while empty -> alloc not granted, free lands.
//  - Alloc+free same cycle, non-empty: both take effect; count unchanged.
//  - ckpt_save: ckpt_head <= head value after this cycle's alloc (head+1 if alloc fires).
//  - flush: head <= ckpt_head; alloc suppressed that cycle; free that cycle still lands.
//    Tail is never rolled back. alloc_ready may be high during flush but alloc does not fire.
//  - flush and ckpt_save together: flush wins, snapshot unchanged.
//  - free_count = tail - head (pointer subtraction, wrap bit included), registered-state derived.
//  - Pointer increment wraps modulo 2*DEPTH; low bits index the array.
//  - Reset mid-operation: all state returns to reset values immediately, independent of clk.
// STRUCTURE
//  - mips_core_pkg gains:
//    localparam PHYS_REGS, ARCH_REGS, PHYS_TAG_W;
//    typedef logic [PHYS_TAG_W-1:0] phys_tag_t (shared with active list and rename map).
//  - Single module, no sub-modules. Pointer logic is too small to factor out.
// TESTING
//  - Reset then no activity -> alloc_ready=1, alloc_tag=32, free_count=32, overflow_err=0.
//  - 32 consecutive allocs -> tags 32..63 in order. Then alloc_ready=0, free_count=0.
//    A 33rd request is not granted.
//  - From empty, free 5 then free 9 -> alloc_ready=1, next allocs return 5 then 9.
//    free_tag=0 leaves count unchanged.
//  - From reset: 3 allocs, ckpt_save with 4th alloc, 4 more allocs, flush with free_tag=7.
//    -> free_count=29 (32-4+1). Next alloc_tag=36.
//  - From reset (full), free_valid with tag 12 -> overflow_err=1, free_count stays 32,
//    and stays set after further traffic.
//  - Mid-sequence (10 allocs, 2 frees), pulse rst_n low between edges -> outputs at reset values
//    before next clk edge.

Source files
------------

// File: rtl/mips_core_pkg.sv
// Core-wide rename parameters and the physical tag type shared by the free list,
// active list and rename map.
package mips_core_pkg;

  localparam int PHYS_REGS  = 64;
  localparam int ARCH_REGS  = 32;
  localparam int PHYS_TAG_W = $clog2(PHYS_REGS);
  localparam int FL_DEPTH   = PHYS_REGS - ARCH_REGS;

  typedef logic [PHYS_TAG_W-1:0] phys_tag_t;

endpackage

// File: rtl/phys_reg_free_list.sv
// Circular FIFO of unallocated physical tags with one read-pointer checkpoint for flush recovery.
// Latency: alloc_tag is combinational from state (zero-cycle grant); frees land at the next edge.
// Backpressure: alloc_ready low when empty; frees are never stalled, a free into a full list is dropped and flagged.
module phys_reg_free_list
  import mips_core_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alloc_req,
  output logic                  alloc_ready,
  output logic [PHYS_TAG_W-1:0] alloc_tag,
  input  logic                  free_valid,
  input  logic [PHYS_TAG_W-1:0] free_tag,
  input  logic                  ckpt_save,
  input  logic                  flush,
  output logic [PHYS_TAG_W-1:0] free_count,
  output logic                  overflow_err
);

  localparam int PTR_W = $clog2(FL_DEPTH) + 1;
  localparam int IDX_W = PTR_W - 1;

  typedef logic [PTR_W-1:0] ptr_t;

  phys_tag_t entry [FL_DEPTH];
  ptr_t      head;
  ptr_t      tail;
  ptr_t      ckpt_head;
  ptr_t      head_adv;
  logic      overflow_q;
  logic      empty;
  logic      full;
  logic      alloc_fire;
  logic      free_req;
  logic      free_push;

  // The MSB is a wrap bit: equal low bits mean empty or full depending on it.
  assign empty      = (head == tail);
  assign full       = (head[PTR_W-1] != tail[PTR_W-1]) &&
                      (head[IDX_W-1:0] == tail[IDX_W-1:0]);
  assign alloc_fire = alloc_req && !empty && !flush;
  // Tag 0 is the hardwired zero register and must never re-enter the pool.
  assign free_req   = free_valid && (free_tag != '0);
  assign free_push  = free_req && !full;
  assign head_adv   = alloc_fire ? head + ptr_t'(1) : head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head       <= '0;
      tail       <= {1'b1, {IDX_W{1'b0}}};
      ckpt_head  <= '0;
      overflow_q <= 1'b0;
    end else begin
      head <= flush ? ckpt_head : head_adv;
      if (free_push) begin
        tail <= tail + ptr_t'(1);
      end
      // Snapshot includes this cycle's alloc so the branch's own dest stays allocated.
      if (ckpt_save && !flush) begin
        ckpt_head <= head_adv;
      end
      if (free_req && full) begin
        overflow_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FL_DEPTH; i++) begin
        entry[i] <= phys_tag_t'(ARCH_REGS + i);
      end
    end else if (free_push) begin
      entry[tail[IDX_W-1:0]] <= free_tag;
    end
  end

  assign alloc_ready  = !empty;
  assign alloc_tag    = entry[head[IDX_W-1:0]];
  assign free_count   = PHYS_TAG_W'(tail - head);
  assign overflow_err = overflow_q;

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Self-checking bench for phys_reg_free_list: directed vector table, hand sequences, randomized run vs. reference model.
module tb_phys_reg_free_list;
  import mips_core_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  alloc_req = 1'b0;
  logic                  alloc_ready;
  logic [PHYS_TAG_W-1:0] alloc_tag;
  logic                  free_valid = 1'b0;
  logic [PHYS_TAG_W-1:0] free_tag = '0;
  logic                  ckpt_save = 1'b0;
  logic                  flush = 1'b0;
  logic [PHYS_TAG_W-1:0] free_count;
  logic                  overflow_err;

  phys_reg_free_list dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alloc_req    (alloc_req),
    .alloc_ready  (alloc_ready),
    .alloc_tag    (alloc_tag),
    .free_valid   (free_valid),
    .free_tag     (free_tag),
    .ckpt_save    (ckpt_save),
    .flush        (flush),
    .free_count   (free_count),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: an unbounded log of every tag ever made free, plus absolute
  // counts of tags handed out and tags pushed. Free pool = log[n_alloc .. n_push-1].
  int log_q[$];
  int n_alloc;
  int n_push;
  int ckpt;
  bit m_ovf;

  typedef struct {
    bit req;
    bit fv;
    int tag;
    bit sv;
    bit fl;
    bit e_rdy;
    int e_tag;
    int e_cnt;
    bit e_ovf;
  } vec_t;

  vec_t vt[15];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    log_q.delete();
    for (int i = 0; i < FL_DEPTH; i++) log_q.push_back(ARCH_REGS + i);
    n_alloc = 0;
    n_push  = FL_DEPTH;
    ckpt    = 0;
    m_ovf   = 1'b0;
  endtask

  task automatic model_step(input bit req, input bit fv, input int tag, input bit sv, input bit fl);
    int  cnt;
    bit  afire;
    bit  freq;
    int  adv;
    cnt   = n_push - n_alloc;
    afire = req && (cnt > 0) && !fl;
    freq  = fv && (tag != 0);
    adv   = n_alloc + (afire ? 1 : 0);
    n_alloc = fl ? ckpt : adv;
    if (freq && cnt < FL_DEPTH) begin
      log_q.push_back(tag);
      n_push++;
    end
    if (sv && !fl) ckpt = adv;
    if (freq && cnt == FL_DEPTH) m_ovf = 1'b1;
  endtask

  task automatic step(input bit req, input bit fv, input int tag, input bit sv, input bit fl);
    alloc_req  = req;
    free_valid = fv;
    free_tag   = PHYS_TAG_W'(tag);
    ckpt_save  = sv;
    flush      = fl;
    @(posedge clk);
    model_step(req, fv, tag, sv, fl);
    #1;
    alloc_req  = 1'b0;
    free_valid = 1'b0;
    free_tag   = '0;
    ckpt_save  = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic do_reset();
    alloc_req  = 1'b0;
    free_valid = 1'b0;
    free_tag   = '0;
    ckpt_save  = 1'b0;
    flush      = 1'b0;
    rst_n      = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_model(input string name);
    chk({name, "_ready"}, int'(alloc_ready), (n_push - n_alloc) > 0 ? 1 : 0);
    if (n_push - n_alloc > 0) chk({name, "_tag"}, int'(alloc_tag), log_q[n_alloc]);
    chk({name, "_count"}, int'(free_count), n_push - n_alloc);
    chk({name, "_ovf"}, int'(overflow_err), int'(m_ovf));
  endtask

  initial begin
    // Checkpoint / flush scenario from reset, expected values after each edge.
    vt[0]  = '{1, 0, 0, 0, 0, 1, 33, 31, 0};
    vt[1]  = '{1, 0, 0, 0, 0, 1, 34, 30, 0};
    vt[2]  = '{1, 0, 0, 0, 0, 1, 35, 29, 0};
    vt[3]  = '{1, 0, 0, 1, 0, 1, 36, 28, 0};
    vt[4]  = '{1, 0, 0, 0, 0, 1, 37, 27, 0};
    vt[5]  = '{1, 0, 0, 0, 0, 1, 38, 26, 0};
    vt[6]  = '{1, 0, 0, 0, 0, 1, 39, 25, 0};
    vt[7]  = '{1, 0, 0, 0, 0, 1, 40, 24, 0};
    vt[8]  = '{1, 1, 7, 0, 1, 1, 36, 29, 0};
    vt[9]  = '{1, 0, 0, 0, 0, 1, 37, 28, 0};
    vt[10] = '{1, 0, 0, 1, 1, 1, 36, 29, 0};
    vt[11] = '{1, 0, 0, 0, 0, 1, 37, 28, 0};
    vt[12] = '{1, 0, 0, 0, 0, 1, 38, 27, 0};
    vt[13] = '{0, 0, 0, 0, 1, 1, 36, 29, 0};
    vt[14] = '{0, 1, 0, 0, 0, 1, 36, 29, 0};

    do_reset();
    chk("reset_ready", int'(alloc_ready), 1);
    chk("reset_tag", int'(alloc_tag), 32);
    chk("reset_count", int'(free_count), 32);
    chk("reset_ovf", int'(overflow_err), 0);

    for (int v = 0; v < 15; v++) begin
      step(vt[v].req, vt[v].fv, vt[v].tag, vt[v].sv, vt[v].fl);
      chk($sformatf("vec%0d_ready", v), int'(alloc_ready), int'(vt[v].e_rdy));
      chk($sformatf("vec%0d_tag", v), int'(alloc_tag), vt[v].e_tag);
      chk($sformatf("vec%0d_count", v), int'(free_count), vt[v].e_cnt);
      chk($sformatf("vec%0d_ovf", v), int'(overflow_err), int'(vt[v].e_ovf));
    end

    // Drain to empty, then refill across the empty boundary.
    do_reset();
    for (int i = 0; i < FL_DEPTH; i++) begin
      chk($sformatf("drain_tag%0d", i), int'(alloc_tag), 32 + i);
      step(1, 0, 0, 0, 0);
    end
    chk("drained_ready", int'(alloc_ready), 0);
    chk("drained_count", int'(free_count), 0);
    step(1, 0, 0, 0, 0);
    chk("req33_ready", int'(alloc_ready), 0);
    chk("req33_count", int'(free_count), 0);
    step(1, 1, 5, 0, 0);
    chk("nobypass_ready", int'(alloc_ready), 1);
    chk("nobypass_count", int'(free_count), 1);
    chk("nobypass_tag", int'(alloc_tag), 5);
    step(0, 1, 9, 0, 0);
    chk("free9_count", int'(free_count), 2);
    step(0, 1, 0, 0, 0);
    chk("free0_count", int'(free_count), 2);
    step(1, 0, 0, 0, 0);
    chk("realloc_tag", int'(alloc_tag), 9);
    chk("realloc_count", int'(free_count), 1);
    step(1, 1, 11, 0, 0);
    chk("allocfree_count", int'(free_count), 1);
    chk("allocfree_tag", int'(alloc_tag), 11);

    // Overflow is sticky.
    do_reset();
    step(0, 1, 12, 0, 0);
    chk("ovf_set", int'(overflow_err), 1);
    chk("ovf_count", int'(free_count), 32);
    chk("ovf_tag", int'(alloc_tag), 32);
    step(1, 1, 20, 0, 0);
    chk("ovf_sticky1", int'(overflow_err), 1);
    chk("ovf_count2", int'(free_count), 31);
    step(0, 1, 13, 0, 0);
    chk("ovf_sticky2", int'(overflow_err), 1);
    chk("ovf_count3", int'(free_count), 32);

    // Asynchronous reset between edges.
    do_reset();
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0);
    step(0, 1, 3, 0, 0);
    step(0, 1, 4, 0, 0);
    chk("premid_count", int'(free_count), 24);
    chk("premid_tag", int'(alloc_tag), 42);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ready", int'(alloc_ready), 1);
    chk("arst_tag", int'(alloc_tag), 32);
    chk("arst_count", int'(free_count), 32);
    chk("arst_ovf", int'(overflow_err), 0);
    model_reset();
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_model("post_arst");

    // Randomized traffic against the reference model.
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      bit req;
      bit fv;
      int tag;
      bit sv;
      bit fl;
      int cnt;
      req = ($urandom_range(0, 99) < 55);
      fv  = ($urandom_range(0, 99) < 45);
      tag = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, PHYS_REGS - 1);
      sv  = ($urandom_range(0, 99) < 10);
      fl  = ($urandom_range(0, 99) < 6);
      cnt = n_push - n_alloc;
      // A real core never frees more than the list can hold past a live checkpoint.
      if (fl && (n_push + ((fv && tag != 0 && cnt < FL_DEPTH) ? 1 : 0) - ckpt > FL_DEPTH)) fl = 1'b0;
      step(req, fv, tag, sv, fl);
      chk_model("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
